if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 30'h0000_0000, word address loaded into the PC on reset.
REQ-002 Clocking: one clock; reset is synchronous and active-high (ports clk, rst).
REQ-003 Port: clk  input  1  clock; all state updates on posedge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: if_addr  output  30  word fetch address to icache_ctrl; combinationally equals the PC register.
REQ-006 Port: cpu_data  input  32  instruction word returned by icache_ctrl.
REQ-007 Port: data_rdy  input  1  cpu_data valid for if_addr this cycle.
REQ-008 Port: miss_stall  input  1  icache miss in progress.
REQ-009 Port: stall  input  1  decode stage cannot accept; hold IF/ID outputs.
REQ-010 Port: flush  input  1  redirect fetch; kill every younger instruction.
REQ-011 Port: new_pc  input  30  redirect word address, sampled when flush=1.
REQ-012 Port: if_pc  output  30  word address of the instruction in if_insn.
REQ-013 Port: if_insn  output  32  IF/ID instruction register.
REQ-014 Port: if_en  output  1  if_insn/if_pc valid.
REQ-015 Port: busy  output  1  high whenever the FSM is not in IF_RUN.

Function
REQ-016 The FSM SHALL have three states: IF_RUN (normal), IF_MISS (cache miss outstanding), IF_MISS_FLUSH (miss outstanding, redirect pending).
REQ-017 Accept: data_rdy=1 in IF_RUN or IF_MISS with flush=0 SHALL take cpu_data for if_addr; the PC then advances by 1 (30-bit wrap: 30'h3FFF_FFFF+1 -> 0).
REQ-018 Accept with stall=0 and skid empty: if_insn<=cpu_data, if_pc<=PC, if_en<=1 on the next edge.
REQ-019 Accept with stall=1 and skid empty: the word and its PC SHALL go into a one-entry skid buffer; outputs hold.
REQ-020 Skid full: data_rdy SHALL be ignored; PC holds, so if_addr stays stable.
REQ-021 stall=0 with skid full: skid moves to outputs (if_en<=1) and the skid empties; a data_rdy in that same cycle SHALL be written into the skid.
REQ-022 stall=0, no accept, skid empty: if_en<=0 (bubble).
REQ-023 stall=1: if_insn, if_pc and if_en SHALL hold unchanged.
REQ-024 IF_RUN, miss_stall=1, flush=0 -> IF_MISS; the PC is frozen for the whole miss.
REQ-025 IF_RUN, flush=1, miss_stall=0: PC<=new_pc, any data_rdy that cycle discarded, stay in IF_RUN.
REQ-026 IF_RUN, flush=1, miss_stall=1 -> IF_MISS_FLUSH; pend_pc<=new_pc; PC frozen.
REQ-027 IF_MISS, data_rdy=1, flush=0: accept per REQ-017..021, then -> IF_RUN.
REQ-028 IF_MISS, flush=1, data_rdy=0: pend_pc<=new_pc, -> IF_MISS_FLUSH.
REQ-029 IF_MISS, flush=1, data_rdy=1: discard the word, PC<=new_pc, -> IF_RUN.
REQ-030 IF_MISS_FLUSH, data_rdy=1: discard the word, PC<=pend_pc, -> IF_RUN; a simultaneous flush SHALL use new_pc instead of pend_pc.
REQ-031 IF_MISS_FLUSH, flush=1, data_rdy=0: pend_pc<=new_pc (last flush wins).
REQ-032 Any flush=1 SHALL clear if_en and the skid on the next edge, overriding stall.
REQ-033 if_addr SHALL NOT change while in IF_MISS or IF_MISS_FLUSH, because icache_ctrl keeps using it through the L2 fill.

Reset
REQ-034 rst=1 SHALL set PC=RESET_PC, pend_pc=0, state=IF_RUN, skid empty, if_en=0, if_insn=32'h0, if_pc=30'h0, busy=0; rst overrides all inputs.
REQ-035 rst asserted mid-miss SHALL return to IF_RUN at RESET_PC, and the late data_rdy SHALL be accepted as the RESET_PC word.

Verification
REQ-036 Hit stream: rst, then data_rdy=1 for 4 cycles with stall=0 and cpu_data=A0..A3 -> if_pc=0,1,2,3 on consecutive cycles with if_en=1; if_addr ends at 4.
REQ-037 Stall/skid: accept at PC=5, then stall=1 for 3 cycles with data_rdy=1 -> skid holds the PC=6 word, if_addr stays 7; stall=0 -> if_pc=6, then 7.
REQ-038 Miss: miss_stall=1 at PC=0x10 for 6 cycles -> busy=1 and if_addr=0x10 throughout; data_rdy with cpu_data=0xDEADBEEF -> if_insn=0xDEADBEEF, if_pc=0x10, if_addr=0x11, busy=0.
REQ-039 Flush during miss: miss at 0x20, flush with new_pc=0x100 and then 0x200 before data_rdy -> if_addr stays 0x20; at data_rdy the word is discarded, if_en=0, next if_addr=0x200.
REQ-040 Wrap/flush-vs-stall: flush new_pc=30'h3FFF_FFFF with stall=1 -> if_en=0; hit -> if_pc=30'h3FFF_FFFF, if_addr=0.

Source files
------------

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if -- fetch bus between the IF stage and icache_ctrl.
//
// Signals:
//   if_addr     word fetch address (driven by the IF stage)
//   cpu_data    instruction word returned by icache_ctrl
//   data_rdy    cpu_data is valid for if_addr this cycle
//   miss_stall  icache miss in progress
//
// Modports:
//   master  IF stage side (drives if_addr)
//   slave   icache_ctrl side (drives cpu_data, data_rdy, miss_stall)
// ---------------------------------------------------------------------------
interface if_stage_if;
    logic [29:0] if_addr;
    logic [31:0] cpu_data;
    logic        data_rdy;
    logic        miss_stall;

    modport master (
        output if_addr,
        input  cpu_data,
        input  data_rdy,
        input  miss_stall
    );

    modport slave (
        input  if_addr,
        output cpu_data,
        output data_rdy,
        output miss_stall
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with miss/redirect FSM and a one-entry
// skid buffer in front of the IF/ID register.
//
// Ports:
//   clk      clock, all state updates on posedge
//   rst      synchronous active-high reset
//   icache   fetch bus (master): if_addr out; cpu_data/data_rdy/miss_stall in
//   stall    decode cannot accept; IF/ID outputs hold
//   flush    redirect fetch to new_pc and kill every younger instruction
//   new_pc   redirect word address, sampled when flush=1
//   if_pc    word address of the instruction in if_insn
//   if_insn  IF/ID instruction register
//   if_en    if_insn/if_pc valid
//   busy     high whenever the FSM is not in IF_RUN
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    if_stage_if.master   icache,
    input  logic         stall,
    input  logic         flush,
    input  logic [29:0]  new_pc,
    output logic [29:0]  if_pc,
    output logic [31:0]  if_insn,
    output logic         if_en,
    output logic         busy
);

    typedef enum logic [1:0] {
        IF_RUN        = 2'd0,
        IF_MISS       = 2'd1,
        IF_MISS_FLUSH = 2'd2
    } state_t;

    state_t      state_q;
    logic [29:0] pc_q;
    logic [29:0] pend_pc_q;
    logic [29:0] skid_pc_q;
    logic [31:0] skid_insn_q;
    logic        skid_v_q;
    logic [29:0] if_pc_q;
    logic [31:0] if_insn_q;
    logic        if_en_q;

    logic        can_take;
    logic        accept;
    logic [29:0] pc_inc;

    // A word can be taken when no redirect is pending/arriving and there is
    // somewhere to put it: either the skid is empty, or it drains this cycle.
    assign can_take = (state_q != IF_MISS_FLUSH) && !flush && (!skid_v_q || !stall);
    assign accept   = icache.data_rdy && can_take;
    assign pc_inc   = pc_q + 30'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IF_RUN;
            pc_q        <= RESET_PC;
            pend_pc_q   <= 30'h0;
            skid_pc_q   <= 30'h0;
            skid_insn_q <= 32'h0;
            skid_v_q    <= 1'b0;
            if_pc_q     <= 30'h0;
            if_insn_q   <= 32'h0;
            if_en_q     <= 1'b0;
        end else begin
            // ---------------- fetch FSM / PC ----------------
            // The PC only moves on an accept or a redirect taken outside a
            // miss; during IF_MISS/IF_MISS_FLUSH icache_ctrl is still using
            // if_addr for the L2 fill, so it is held.
            case (state_q)
                IF_RUN: begin
                    if (flush) begin
                        if (icache.miss_stall) begin
                            pend_pc_q <= new_pc;
                            state_q   <= IF_MISS_FLUSH;
                        end else begin
                            pc_q <= new_pc;
                        end
                    end else if (accept) begin
                        // A word delivered for the current PC is a hit even
                        // if miss_stall is raised alongside it.
                        pc_q <= pc_inc;
                    end else if (icache.miss_stall) begin
                        state_q <= IF_MISS;
                    end
                end
                IF_MISS: begin
                    if (flush) begin
                        if (icache.data_rdy) begin
                            pc_q    <= new_pc;
                            state_q <= IF_RUN;
                        end else begin
                            pend_pc_q <= new_pc;
                            state_q   <= IF_MISS_FLUSH;
                        end
                    end else if (accept) begin
                        pc_q    <= pc_inc;
                        state_q <= IF_RUN;
                    end
                end
                IF_MISS_FLUSH: begin
                    if (icache.data_rdy) begin
                        // Fill word belongs to the dead path; resume at the
                        // newest redirect target.
                        pc_q    <= flush ? new_pc : pend_pc_q;
                        state_q <= IF_RUN;
                    end else if (flush) begin
                        pend_pc_q <= new_pc;
                    end
                end
                default: begin
                    state_q <= IF_RUN;
                end
            endcase

            // ---------------- skid buffer / IF/ID register ----------------
            if (flush) begin
                if_en_q  <= 1'b0;
                skid_v_q <= 1'b0;
            end else if (stall) begin
                if (accept) begin
                    skid_insn_q <= icache.cpu_data;
                    skid_pc_q   <= pc_q;
                    skid_v_q    <= 1'b1;
                end
            end else if (skid_v_q) begin
                // Skid drains to the outputs; a word arriving now refills it
                // so ordering is preserved.
                if_insn_q <= skid_insn_q;
                if_pc_q   <= skid_pc_q;
                if_en_q   <= 1'b1;
                skid_v_q  <= accept;
                if (accept) begin
                    skid_insn_q <= icache.cpu_data;
                    skid_pc_q   <= pc_q;
                end
            end else if (accept) begin
                if_insn_q <= icache.cpu_data;
                if_pc_q   <= pc_q;
                if_en_q   <= 1'b1;
            end else begin
                if_en_q <= 1'b0;
            end
        end
    end

    assign icache.if_addr = pc_q;
    assign if_pc          = if_pc_q;
    assign if_insn        = if_insn_q;
    assign if_en          = if_en_q;
    assign busy           = (state_q != IF_RUN);

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed bench for if_stage. Expected IF/ID words are pushed
// to a scoreboard when the fetch is driven and popped whenever the stage
// presents a new valid word.
// ---------------------------------------------------------------------------
module tb_if_stage;

    typedef struct {
        logic [29:0] pc;
        logic [31:0] insn;
    } sb_entry_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [29:0] new_pc;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    sb_entry_t sb[$];

    if_stage_if bus();

    if_stage #(.RESET_PC(30'h0000_0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .icache  (bus),
        .stall   (stall),
        .flush   (flush),
        .new_pc  (new_pc),
        .if_pc   (if_pc),
        .if_insn (if_insn),
        .if_en   (if_en),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [29:0] pc, input logic [31:0] insn);
        sb_entry_t e;
        e.pc   = pc;
        e.insn = insn;
        sb.push_back(e);
    endtask

    // One clock: drive inputs, clock, then sample 1 time unit after the edge.
    // If the outputs were allowed to update and now show a valid word, it must
    // be the oldest scoreboard entry.
    task automatic step(input logic r, input logic dr, input logic [31:0] d,
                        input logic ms, input logic st, input logic fl,
                        input logic [29:0] np);
        logic      was_upd;
        sb_entry_t e;
        rst             = r;
        bus.data_rdy    = dr;
        bus.cpu_data    = d;
        bus.miss_stall  = ms;
        stall           = st;
        flush           = fl;
        new_pc          = np;
        was_upd         = !r && !st && !fl;
        @(posedge clk);
        #1;
        if (was_upd && if_en) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_pc", 32'(if_pc), 32'(e.pc));
                chk("sb_insn", if_insn, e.insn);
            end
        end
        $display("t=%0t rst=%0b dr=%0b ms=%0b st=%0b fl=%0b np=%h | if_addr=%h if_en=%0b if_pc=%h if_insn=%h busy=%0b",
                 $time, r, dr, ms, st, fl, np, bus.if_addr, if_en, if_pc, if_insn, busy);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 30'h0;
        bus.data_rdy = 1'b0; bus.cpu_data = 32'h0; bus.miss_stall = 1'b0;

        // ---- reset ----
        step(1, 1, 32'hFFFF_FFFF, 1, 0, 1, 30'h123);
        step(1, 0, 32'h0, 0, 0, 0, 30'h0);
        chk("rst_if_en", 32'(if_en), 32'd0);
        chk("rst_if_addr", 32'(bus.if_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_if_insn", if_insn, 32'd0);

        // ---- hit stream PC 0..3 ----
        for (int i = 0; i < 4; i++) begin
            push(30'(i), 32'hA000_0000 + 32'(i));
            step(0, 1, 32'hA000_0000 + 32'(i), 0, 0, 0, 30'h0);
            chk("hit_if_en", 32'(if_en), 32'd1);
        end
        chk("hit_if_addr", 32'(bus.if_addr), 32'd4);

        // ---- stall / skid ----
        push(30'd4, 32'hB000_0004); step(0, 1, 32'hB000_0004, 0, 0, 0, 30'h0);
        push(30'd5, 32'hB000_0005); step(0, 1, 32'hB000_0005, 0, 0, 0, 30'h0);
        push(30'd6, 32'hB000_0006); step(0, 1, 32'hB000_0006, 0, 1, 0, 30'h0);
        chk("skid_hold_pc", 32'(if_pc), 32'd5);
        chk("skid_addr1", 32'(bus.if_addr), 32'd7);
        step(0, 1, 32'hBAD0_0001, 0, 1, 0, 30'h0);
        chk("skid_addr2", 32'(bus.if_addr), 32'd7);
        chk("skid_hold_insn", if_insn, 32'hB000_0005);
        step(0, 1, 32'hBAD0_0002, 0, 1, 0, 30'h0);
        chk("skid_addr3", 32'(bus.if_addr), 32'd7);
        push(30'd7, 32'hB000_0007); step(0, 1, 32'hB000_0007, 0, 0, 0, 30'h0);
        chk("skid_refill_addr", 32'(bus.if_addr), 32'd8);
        step(0, 0, 32'h0, 0, 0, 0, 30'h0);
        chk("skid_drain_en", 32'(if_en), 32'd1);
        step(0, 0, 32'h0, 0, 0, 0, 30'h0);
        chk("bubble_en", 32'(if_en), 32'd0);

        // ---- flush empties a full skid even under stall ----
        step(0, 1, 32'hC000_0008, 0, 1, 0, 30'h0);
        step(0, 0, 32'h0, 0, 1, 1, 30'h10);
        chk("flush_skid_en", 32'(if_en), 32'd0);
        chk("flush_addr", 32'(bus.if_addr), 32'h10);
        step(0, 0, 32'h0, 0, 0, 0, 30'h0);
        chk("flush_skid_gone", 32'(if_en), 32'd0);

        // ---- miss at 0x10 ----
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 32'h0, 1, 0, 0, 30'h0);
            chk("miss_busy", 32'(busy), 32'd1);
            chk("miss_addr", 32'(bus.if_addr), 32'h10);
        end
        push(30'h10, 32'hDEAD_BEEF); step(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 30'h0);
        chk("miss_done_addr", 32'(bus.if_addr), 32'h11);
        chk("miss_done_busy", 32'(busy), 32'd0);

        // ---- flush during miss, last flush wins ----
        step(0, 0, 32'h0, 0, 0, 1, 30'h20);
        step(0, 0, 32'h0, 1, 0, 0, 30'h0);
        step(0, 0, 32'h0, 1, 0, 1, 30'h100);
        chk("mf_addr1", 32'(bus.if_addr), 32'h20);
        chk("mf_busy", 32'(busy), 32'd1);
        step(0, 0, 32'h0, 1, 0, 1, 30'h200);
        chk("mf_addr2", 32'(bus.if_addr), 32'h20);
        step(0, 0, 32'h0, 1, 0, 0, 30'h0);
        chk("mf_addr3", 32'(bus.if_addr), 32'h20);
        step(0, 1, 32'hBAD0_0003, 0, 0, 0, 30'h0);
        chk("mf_discard_en", 32'(if_en), 32'd0);
        chk("mf_resume_addr", 32'(bus.if_addr), 32'h200);
        chk("mf_resume_busy", 32'(busy), 32'd0);

        // ---- IF_MISS with flush and data_rdy together ----
        step(0, 0, 32'h0, 1, 0, 0, 30'h0);
        step(0, 1, 32'hBAD0_0004, 0, 0, 1, 30'h300);
        chk("mfd_addr", 32'(bus.if_addr), 32'h300);
        chk("mfd_busy", 32'(busy), 32'd0);
        chk("mfd_en", 32'(if_en), 32'd0);

        // ---- IF_MISS_FLUSH: simultaneous flush beats pend_pc ----
        step(0, 0, 32'h0, 1, 0, 0, 30'h0);
        step(0, 0, 32'h0, 1, 0, 1, 30'h350);
        step(0, 1, 32'hBAD0_0005, 0, 0, 1, 30'h400);
        chk("mff_addr", 32'(bus.if_addr), 32'h400);
        chk("mff_busy", 32'(busy), 32'd0);

        // ---- flush over stall, then wrap ----
        push(30'h400, 32'hE000_0000); step(0, 1, 32'hE000_0000, 0, 0, 0, 30'h0);
        chk("wrap_pre_en", 32'(if_en), 32'd1);
        step(0, 0, 32'h0, 0, 1, 1, 30'h3FFF_FFFF);
        chk("wrap_flush_en", 32'(if_en), 32'd0);
        chk("wrap_flush_addr", 32'(bus.if_addr), 32'h3FFF_FFFF);
        push(30'h3FFF_FFFF, 32'hE000_0001); step(0, 1, 32'hE000_0001, 0, 0, 0, 30'h0);
        chk("wrap_addr", 32'(bus.if_addr), 32'd0);

        // ---- reset mid-miss, late word accepted at RESET_PC ----
        push(30'h0, 32'hE000_0002); step(0, 1, 32'hE000_0002, 0, 0, 0, 30'h0);
        step(0, 0, 32'h0, 1, 0, 0, 30'h0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_addr", 32'(bus.if_addr), 32'd1);
        step(1, 0, 32'h0, 1, 0, 0, 30'h0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(bus.if_addr), 32'd0);
        chk("mid_rst_en", 32'(if_en), 32'd0);
        push(30'h0, 32'hE000_0003); step(0, 1, 32'hE000_0003, 0, 0, 0, 30'h0);
        chk("post_rst_addr", 32'(bus.if_addr), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
